ahb_sram_responder: RTL and testbench

AHB_SRAM_RESPONDER -- requirements
Module: ahb_sram_responder

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_sram_responder_mem.sv | 21 ++
 rtl/ahb_sram_responder.sv | 93 +++++++++
 tb/tb_ahb_sram_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, responder FSM states and lane helpers.
// Contents: htrans_t, hsize_t, hresp_t, state_t, misaligned(), byte_en().
package ahb_pkg;
   typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
   typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD} hsize_t;
   typedef enum logic {HRESP_OKAY, HRESP_ERROR} hresp_t;
   typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
      return (size == HSIZE_HALF && off[0]) || (size == HSIZE_WORD && off != 2'b00);
   endfunction

   // little-endian lane selection; only legal (aligned, size<=2) transfers reach this
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
      return size == HSIZE_WORD ? 4'b1111 :
             size == HSIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
             4'b0001 << off;
   endfunction
endpackage

// File: rtl/ahb_sram_responder_mem.sv
// ahb_sram_responder_mem: word-wide backing store, byte-enabled write, async read.
// Ports: clock; we/be/addr/wdata write port; rdata combinational read of addr.
module ahb_sram_responder_mem #(
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clock)
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

   assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite SRAM subordinate with fixed wait states and two-cycle ERROR.
// Ports: clock, reset (async, active low); auto_in_h* AHB-Lite address/data-phase inputs;
//        auto_in_hreadyout, auto_in_hresp, auto_in_hrdata responder outputs.
module ahb_sram_responder
   import ahb_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        auto_in_hsel,
   input  logic        auto_in_hready,
   input  logic [1:0]  auto_in_htrans,
   input  logic [2:0]  auto_in_hsize,
   input  logic [2:0]  auto_in_hburst,
   input  logic        auto_in_hwrite,
   input  logic [3:0]  auto_in_hprot,
   input  logic        auto_in_hmastlock,
   input  logic [29:0] auto_in_haddr,
   input  logic [31:0] auto_in_hwdata,
   output logic        auto_in_hreadyout,
   output logic        auto_in_hresp,
   output logic [31:0] auto_in_hrdata
);
   localparam int AW = $clog2(DEPTH_WORDS);

   state_t        state, state_nx;
   logic [2:0]    cnt, cnt_nx;
   logic [AW+1:0] addr_q;
   logic [2:0]    size_q;
   logic          wr_q;
   logic          accept, bad, load;
   logic [31:0]   rdata;
   logic          unused_ok;

   assign unused_ok = ^{auto_in_hburst, auto_in_hprot, auto_in_hmastlock, auto_in_htrans[0]};

   assign accept = auto_in_hsel & auto_in_hready & auto_in_htrans[1];
   assign bad = (auto_in_haddr[29:2] >= 28'(DEPTH_WORDS)) || (auto_in_hsize > HSIZE_WORD) ||
                misaligned(auto_in_hsize, auto_in_haddr[1:0]);

   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      load = 1'b0;
      case (state)
         IDLE, DATA, ERR2: begin
            // DATA and ERR2 drive hreadyout=1, so a new address phase completes here
            state_nx = !accept ? IDLE : bad ? ERR1 : (WAIT_STATES == 0 ? DATA : WAIT);
            cnt_nx = accept && !bad ? 3'(WAIT_STATES) : 3'd0;
            load = accept && !bad;
         end
         WAIT: begin
            cnt_nx = cnt - 3'd1;
            state_nx = cnt == 3'd1 ? DATA : WAIT;
         end
         ERR1: state_nx = ERR2;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         addr_q <= '0;
         size_q <= '0;
         wr_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (load) begin
            addr_q <= auto_in_haddr[AW+1:0];
            size_q <= auto_in_hsize;
            wr_q <= auto_in_hwrite;
         end
      end

   // outputs decode from state alone so reset takes effect without a clock edge
   assign auto_in_hreadyout = state == IDLE || state == DATA || state == ERR2;
   assign auto_in_hresp = state == ERR1 || state == ERR2 ? HRESP_ERROR : HRESP_OKAY;
   assign auto_in_hrdata = state == DATA && !wr_q ? rdata : 32'd0;

   ahb_sram_responder_mem #(.DEPTH(DEPTH_WORDS)) u_mem (
      .clock(clock),
      .we(state == DATA && wr_q),
      .be(byte_en(size_q, addr_q[1:0])),
      .addr(addr_q[AW+1:2]),
      .wdata(auto_in_hwdata),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb_ahb_sram_responder: directed bench for ahb_sram_responder (WAIT_STATES=1 and 0 instances).
module tb_ahb_sram_responder;
   import ahb_pkg::*;

   logic        clock = 1'b0, reset = 1'b0, hsel0 = 1'b0, hsel1 = 1'b0, use0 = 1'b0;
   logic [1:0]  htrans = HTRANS_IDLE;
   logic [2:0]  hsize = 3'd2, hburst = 3'd0;
   logic        hwrite = 1'b0, hmastlock = 1'b0;
   logic [3:0]  hprot = 4'd0;
   logic [29:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic        ro0, ro1, rsp0, rsp1, ro, rsp, hready;
   logic [31:0] rd0, rd1, rd;
   int          n_cmp = 0, n_err = 0;

   always #5 clock = ~clock;

   assign ro = use0 ? ro0 : ro1;
   assign rsp = use0 ? rsp0 : rsp1;
   assign rd = use0 ? rd0 : rd1;
   assign hready = ro;

   ahb_sram_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clock(clock), .reset(reset), .auto_in_hsel(hsel0), .auto_in_hready(hready),
      .auto_in_htrans(htrans), .auto_in_hsize(hsize), .auto_in_hburst(hburst),
      .auto_in_hwrite(hwrite), .auto_in_hprot(hprot), .auto_in_hmastlock(hmastlock),
      .auto_in_haddr(haddr), .auto_in_hwdata(hwdata), .auto_in_hreadyout(ro0),
      .auto_in_hresp(rsp0), .auto_in_hrdata(rd0));

   ahb_sram_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut1 (
      .clock(clock), .reset(reset), .auto_in_hsel(hsel1), .auto_in_hready(hready),
      .auto_in_htrans(htrans), .auto_in_hsize(hsize), .auto_in_hburst(hburst),
      .auto_in_hwrite(hwrite), .auto_in_hprot(hprot), .auto_in_hmastlock(hmastlock),
      .auto_in_haddr(haddr), .auto_in_hwdata(hwdata), .auto_in_hreadyout(ro1),
      .auto_in_hresp(rsp1), .auto_in_hrdata(rd1));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic addr_phase(input logic w, input logic [29:0] a, input logic [2:0] sz);
      htrans = HTRANS_NONSEQ;
      hwrite = w;
      haddr = a;
      hsize = sz;
   endtask

   task automatic okay_xfer(input string tag, input logic w, input logic [29:0] a,
                            input logic [2:0] sz, input logic [31:0] wd, input int waits,
                            input logic [31:0] exp_rd);
      addr_phase(w, a, sz);
      tick();
      htrans = HTRANS_IDLE;
      hwdata = wd;
      for (int i = 0; i < waits; i++) begin
         chk({tag, " wait hreadyout"}, 32'(ro), 32'd0);
         chk({tag, " wait hresp"}, 32'(rsp), 32'd0);
         tick();
      end
      chk({tag, " data hreadyout"}, 32'(ro), 32'd1);
      chk({tag, " data hresp"}, 32'(rsp), 32'd0);
      chk({tag, " hrdata"}, rd, exp_rd);
      tick();
   endtask

   task automatic err_xfer(input string tag, input logic w, input logic [29:0] a,
                           input logic [2:0] sz, input logic [31:0] wd);
      addr_phase(w, a, sz);
      tick();
      htrans = HTRANS_IDLE;
      hwdata = wd;
      chk({tag, " err1 hreadyout"}, 32'(ro), 32'd0);
      chk({tag, " err1 hresp"}, 32'(rsp), 32'd1);
      tick();
      chk({tag, " err2 hreadyout"}, 32'(ro), 32'd1);
      chk({tag, " err2 hresp"}, 32'(rsp), 32'd1);
      chk({tag, " err2 hrdata"}, rd, 32'd0);
      tick();
      chk({tag, " idle hresp"}, 32'(rsp), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst ro0", 32'(ro0), 32'd1);
      chk("rst rsp0", 32'(rsp0), 32'd0);
      chk("rst rd0", rd0, 32'd0);
      chk("rst ro1", 32'(ro1), 32'd1);
      chk("rst rsp1", 32'(rsp1), 32'd0);
      chk("rst rd1", rd1, 32'd0);
      reset = 1'b1;
      tick();
      hsel1 = 1'b1;
      okay_xfer("wr10", 1'b1, 30'h10, 3'd2, 32'hDEADBEEF, 1, 32'd0);
      okay_xfer("rd10", 1'b0, 30'h10, 3'd2, 32'd0, 1, 32'hDEADBEEF);
      okay_xfer("wr10w", 1'b1, 30'h10, 3'd2, 32'h11223344, 1, 32'd0);
      okay_xfer("wrb13", 1'b1, 30'h13, 3'd0, 32'hAA000000, 1, 32'd0);
      okay_xfer("rdb13", 1'b0, 30'h10, 3'd2, 32'd0, 1, 32'hAA223344);
      okay_xfer("wrh12", 1'b1, 30'h12, 3'd1, 32'hBEEF0000, 1, 32'd0);
      okay_xfer("rdh12", 1'b0, 30'h10, 3'd2, 32'd0, 1, 32'hBEEF3344);
      okay_xfer("wr0", 1'b1, 30'h0, 3'd2, 32'h12345678, 1, 32'd0);
      err_xfer("rd400", 1'b0, 30'h400, 3'd2, 32'd0);
      err_xfer("wr2mis", 1'b1, 30'h2, 3'd2, 32'hFFFFFFFF);
      err_xfer("wr400", 1'b1, 30'h400, 3'd2, 32'hFFFFFFFF);
      err_xfer("wrsz3", 1'b1, 30'h0, 3'd3, 32'hFFFFFFFF);
      okay_xfer("rd0 after err", 1'b0, 30'h0, 3'd2, 32'd0, 1, 32'h12345678);
      addr_phase(1'b0, 30'h400, 3'd2);
      tick();
      htrans = HTRANS_IDLE;
      chk("b2b err1 hresp", 32'(rsp), 32'd1);
      tick();
      chk("b2b err2 hreadyout", 32'(ro), 32'd1);
      addr_phase(1'b0, 30'h10, 3'd2);
      tick();
      htrans = HTRANS_IDLE;
      chk("err2->wait hreadyout", 32'(ro), 32'd0);
      chk("err2->wait hresp", 32'(rsp), 32'd0);
      tick();
      chk("err2->data hrdata", rd, 32'hBEEF3344);
      tick();
      htrans = HTRANS_BUSY;
      hwrite = 1'b1;
      haddr = 30'h10;
      hsize = 3'd2;
      hwdata = 32'd0;
      tick();
      chk("busy hreadyout", 32'(ro), 32'd1);
      chk("busy hresp", 32'(rsp), 32'd0);
      tick();
      chk("busy hreadyout 2", 32'(ro), 32'd1);
      htrans = HTRANS_IDLE;
      okay_xfer("rd after busy", 1'b0, 30'h10, 3'd2, 32'd0, 1, 32'hBEEF3344);
      addr_phase(1'b1, 30'h10, 3'd2);
      tick();
      htrans = HTRANS_IDLE;
      hwdata = 32'hCAFEF00D;
      chk("pre-rst wait hreadyout", 32'(ro), 32'd0);
      #1 reset = 1'b0;
      #1;
      chk("mid-wait rst hreadyout", 32'(ro), 32'd1);
      chk("mid-wait rst hresp", 32'(rsp), 32'd0);
      chk("mid-wait rst hrdata", rd, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      okay_xfer("rd after rst", 1'b0, 30'h10, 3'd2, 32'd0, 1, 32'hBEEF3344);
      hsel1 = 1'b0;
      hsel0 = 1'b1;
      use0 = 1'b1;
      addr_phase(1'b1, 30'h0, 3'd2);
      tick();
      chk("b2b wr data hreadyout", 32'(ro), 32'd1);
      hwdata = 32'h00000055;
      addr_phase(1'b0, 30'h0, 3'd2);
      tick();
      htrans = HTRANS_IDLE;
      chk("b2b rd hreadyout", 32'(ro), 32'd1);
      chk("b2b rd hresp", 32'(rsp), 32'd0);
      chk("b2b rd hrdata", rd, 32'h00000055);
      tick();
      chk("b2b idle hrdata", rd, 32'd0);
      okay_xfer("ws0 rd0", 1'b0, 30'h0, 3'd2, 32'd0, 0, 32'h00000055);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
